// File: rtl/bram_byte_rmw.sv
`default_nettype none
// bram_byte_rmw: word access adapter with per-byte write mask for a RAM port that has no byte enables.
// Partial-mask writes become read-merge-write; rev 1.0.
module bram_byte_rmw #(
  parameter int DATA_WIDTH = 32,
  parameter int MASK_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic                  i_request,
  input  logic                  i_rw,
  input  logic [31:0]           i_address,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [MASK_WIDTH-1:0] i_wmask,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_ready,
  output logic                  o_busy,
  output logic                  o_mem_request,
  output logic                  o_mem_rw,
  output logic [31:0]           o_mem_address,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  input  logic                  i_mem_ready
);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    RD_WAIT      = 3'd1,
    WR_WAIT      = 3'd2,
    RMW_RD_WAIT  = 3'd3,
    RMW_WR_ISSUE = 3'd4,
    ACK          = 3'd5
  } state_t;

  localparam logic [MASK_WIDTH-1:0] FULL_MASK = '1;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [MASK_WIDTH-1:0] wmask_q, wmask_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_rw_q, mem_rw_d;
  logic [31:0]           mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= IDLE;
      wdata_q     <= '0;
      wmask_q     <= '0;
      rdata_q     <= '0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      rdata_q     <= rdata_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      mem_req_q   <= mem_req_d;
      mem_rw_q    <= mem_rw_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Every output register is loaded from the value it must show in the state being entered.
  always_comb begin
    state_d     = state_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    rdata_d     = '0;
    mem_req_d   = 1'b0;
    mem_rw_d    = mem_rw_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      IDLE: begin
        if (i_request) begin
          wdata_d    = i_wdata;
          wmask_d    = i_wmask;
          mem_addr_d = i_address & ~32'h3;
          if (!i_rw) begin
            mem_req_d = 1'b1;
            mem_rw_d  = 1'b0;
            state_d   = RD_WAIT;
          end else if (i_wmask == FULL_MASK) begin
            mem_req_d   = 1'b1;
            mem_rw_d    = 1'b1;
            mem_wdata_d = i_wdata;
            state_d     = WR_WAIT;
          end else if (i_wmask == '0) begin
            state_d = ACK;
          end else begin
            mem_req_d = 1'b1;
            mem_rw_d  = 1'b0;
            state_d   = RMW_RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (i_mem_ready) begin
          rdata_d = i_mem_rdata;
          state_d = ACK;
        end
      end
      WR_WAIT: begin
        if (i_mem_ready) state_d = ACK;
      end
      RMW_RD_WAIT: begin
        if (i_mem_ready) begin
          for (int n = 0; n < MASK_WIDTH; n++) begin
            mem_wdata_d[8*n +: 8] = wmask_q[n] ? wdata_q[8*n +: 8] : i_mem_rdata[8*n +: 8];
          end
          mem_req_d = 1'b1;
          mem_rw_d  = 1'b1;
          state_d   = RMW_WR_ISSUE;
        end
      end
      RMW_WR_ISSUE: state_d = WR_WAIT;
      ACK:          state_d = IDLE;
      default:      state_d = IDLE;
    endcase

    ready_d = (state_d == ACK);
    busy_d  = (state_d != IDLE);
  end

  assign o_rdata       = rdata_q;
  assign o_ready       = ready_q;
  assign o_busy        = busy_q;
  assign o_mem_request = mem_req_q;
  assign o_mem_rw      = mem_rw_q;
  assign o_mem_address = mem_addr_q;
  assign o_mem_wdata   = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_bram_byte_rmw.sv
`default_nettype none
// tb_bram_byte_rmw: transaction-level reference model plus single-cycle RAM responder;
// directed scenarios followed by randomized accesses.
module tb_bram_byte_rmw;

  localparam int K_NONE = 0, K_READ = 1, K_FULL = 2, K_ZERO = 3, K_PART = 4;

  logic        clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_request = 1'b0;
  logic        i_rw = 1'b0;
  logic [31:0] i_address = '0;
  logic [31:0] i_wdata = '0;
  logic [3:0]  i_wmask = '0;
  logic [31:0] o_rdata;
  logic        o_ready, o_busy, o_mem_request, o_mem_rw;
  logic [31:0] o_mem_address, o_mem_wdata;
  logic [31:0] i_mem_rdata = '0;
  logic        i_mem_ready = 1'b0;

  bram_byte_rmw #(.DATA_WIDTH(32)) dut (
    .i_clock(clk), .i_reset_n(i_reset_n), .i_request(i_request), .i_rw(i_rw),
    .i_address(i_address), .i_wdata(i_wdata), .i_wmask(i_wmask),
    .o_rdata(o_rdata), .o_ready(o_ready), .o_busy(o_busy),
    .o_mem_request(o_mem_request), .o_mem_rw(o_mem_rw),
    .o_mem_address(o_mem_address), .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(i_mem_rdata), .i_mem_ready(i_mem_ready)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int n_cmp = 0, n_bad = 0;

  // RAM contents as the responder sees them, and the memory the model expects.
  logic [31:0] ram [256];
  logic [31:0] model_mem [256];

  // Model of the transaction in flight.
  int          m_kind = K_NONE;
  bit          m_zero = 1'b1;
  int          m_t = 0;
  int          m_w = 0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;

  // RAM responder: executes the access on the request cycle, ready one cycle later.
  bit          pend = 1'b0, stray = 1'b0;
  logic [31:0] pend_data = '0, last_wr = '0;
  int          n_req = 0;
  initial forever begin
    @(negedge clk);
    i_mem_ready = pend | stray;
    i_mem_rdata = pend ? pend_data : $urandom();
    pend = 1'b0;
    if (o_mem_request === 1'b1) begin
      pend = 1'b1;
      n_req++;
      if (o_mem_rw) begin
        ram[o_mem_address[9:2]] = o_mem_wdata;
        last_wr = o_mem_wdata;
      end else begin
        pend_data = ram[o_mem_address[9:2]];
      end
    end
  end

  // Per-cycle compare against the timeline implied by the model transaction.
  initial forever begin
    int k;
    logic e_rdy, e_busy, e_req, e_rw;
    logic [31:0] e_addr, e_wd, e_rd;
    bit c_bus, c_wd, c_rd, bad;
    @(negedge clk);
    k = cyc - m_t;
    e_rdy = 0; e_busy = 0; e_req = 0; e_rw = 0;
    e_addr = m_addr; e_wd = m_wdata; e_rd = '0;
    c_bus = 0; c_wd = 0; c_rd = 0;
    case (m_kind)
      K_READ: begin
        e_busy = (k >= 1 && k <= 3); e_req = (k == 1); e_rdy = (k == 3);
        c_rd = (k == 3); e_rd = m_rdata; c_bus = (k == 1 || k == 2);
      end
      K_FULL: begin
        e_busy = (k >= 1 && k <= 3); e_req = (k == 1); e_rdy = (k == 3);
        c_rd = (k == 3); c_bus = (k == 1 || k == 2); c_wd = c_bus; e_rw = 1;
      end
      K_ZERO: begin
        e_busy = (k == 1); e_rdy = (k == 1); c_rd = (k == 1);
      end
      K_PART: begin
        e_busy = (k >= 1 && k <= 5); e_req = (k == 1 || k == 3); e_rdy = (k == 5);
        c_rd = (k == 5); c_bus = (k >= 1 && k <= 4); e_rw = (k >= 3);
        c_wd = (k == 3 || k == 4);
      end
      default: begin
        if (m_zero) begin
          c_bus = 1; c_wd = 1; c_rd = 1; e_addr = '0; e_wd = '0;
        end
      end
    endcase
    bad = (o_ready !== e_rdy) || (o_busy !== e_busy) || (o_mem_request !== e_req);
    if (c_rd && o_rdata !== e_rd) bad = 1;
    if (c_bus && (o_mem_address !== e_addr || o_mem_rw !== e_rw)) bad = 1;
    if (c_wd && o_mem_wdata !== e_wd) bad = 1;
    n_cmp++;
    if (bad) begin
      n_bad++;
      $display("FAIL cycle cyc=%0d kind=%0d k=%0d got rdy=%b busy=%b req=%b rw=%b addr=%h wd=%h rd=%h want rdy=%b busy=%b req=%b rw=%b addr=%h wd=%h rd=%h",
               cyc, m_kind, k, o_ready, o_busy, o_mem_request, o_mem_rw, o_mem_address,
               o_mem_wdata, o_rdata, e_rdy, e_busy, e_req, e_rw, e_addr, e_wd, e_rd);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  function automatic int exp_lat(input logic rw, input logic [3:0] mask);
    if (!rw) return 3;
    if (mask == 4'hF) return 3;
    if (mask == 4'h0) return 1;
    return 5;
  endfunction

  task automatic set_model(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] mask, input int t);
    logic [31:0] old;
    m_w    = int'(addr[9:2]);
    old    = model_mem[m_w];
    m_addr = {addr[31:2], 2'b00};
    m_rdata = old;
    for (int b = 0; b < 4; b++) m_wdata[8*b +: 8] = mask[b] ? wdata[8*b +: 8] : old[8*b +: 8];
    if (!rw)                m_kind = K_READ;
    else if (mask == 4'hF)  m_kind = K_FULL;
    else if (mask == 4'h0)  m_kind = K_ZERO;
    else                    m_kind = K_PART;
    m_zero = 1'b0;
    m_t = t;
  endtask

  task automatic scramble();
    i_rw = 1'($urandom()); i_address = $urandom(); i_wdata = $urandom(); i_wmask = 4'($urandom());
  endtask

  task automatic start_txn(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] mask);
    @(negedge clk);
    #1;
    i_request = 1'b1; i_rw = rw; i_address = addr; i_wdata = wdata; i_wmask = mask;
    set_model(rw, addr, wdata, mask, cyc);
  endtask

  task automatic wait_done(output int lat, output logic [31:0] rd, input bit hold);
    int n;
    n = 0; lat = -1; rd = '0;
    while (1) begin
      @(negedge clk);
      n++;
      if (o_ready === 1'b1 || n >= 30) break;
      #1;
      if (!hold) scramble();
    end
    if (o_ready !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout: no o_ready within 30 cycles, kind=%0d", m_kind);
      m_kind = K_NONE;
      #1;
      i_request = 1'b0;
    end else begin
      lat = cyc - m_t;
      rd = o_rdata;
      if (m_kind == K_FULL || m_kind == K_PART) model_mem[m_w] = m_wdata;
      #1;
      if (!hold) begin
        i_request = 1'b0;
        scramble();
      end
    end
  endtask

  task automatic run_txn(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] mask, output int lat, output logic [31:0] rd);
    start_txn(rw, addr, wdata, mask);
    wait_done(lat, rd, 1'b0);
  endtask

  initial begin
    int lat, lat2, r0, diffs;
    logic [31:0] rd, rd2, a, d;
    logic [3:0] mk;
    logic rw;
    for (int i = 0; i < 256; i++) begin
      ram[i] = $urandom();
      model_mem[i] = ram[i];
    end
    ram[4] = 32'hDEADBEEF; model_mem[4] = 32'hDEADBEEF;
    repeat (3) @(negedge clk);
    #1 i_reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Read of word 4.
    r0 = n_req;
    run_txn(1'b0, 32'h10, 32'h0, 4'hF, lat, rd);
    chk("read_rdata", rd, 32'hDEADBEEF);
    chk("read_lat", 32'(lat), 32'd3);
    chk("read_nreq", 32'(n_req - r0), 32'd1);

    // Full-mask write.
    r0 = n_req;
    run_txn(1'b1, 32'h20, 32'h12345678, 4'b1111, lat, rd);
    chk("full_wdata", last_wr, 32'h12345678);
    chk("full_lat", 32'(lat), 32'd3);
    chk("full_nreq", 32'(n_req - r0), 32'd1);

    // Partial-mask write: read, merge, write.
    ram[8] = 32'hAABBCCDD; model_mem[8] = 32'hAABBCCDD;
    r0 = n_req;
    run_txn(1'b1, 32'h22, 32'h11223344, 4'b0101, lat, rd);
    chk("part_ram", ram[8], 32'hAA22CC44);
    chk("part_lat", 32'(lat), 32'd5);
    chk("part_nreq", 32'(n_req - r0), 32'd2);

    // Empty-mask write touches no RAM.
    r0 = n_req;
    run_txn(1'b1, 32'h40, 32'h55555555, 4'b0000, lat, rd);
    chk("zero_lat", 32'(lat), 32'd1);
    chk("zero_nreq", 32'(n_req - r0), 32'd0);

    // Request held two cycles past o_ready starts exactly one more read.
    r0 = n_req;
    start_txn(1'b0, 32'h20, 32'h0, 4'h0);
    wait_done(lat, rd, 1'b1);
    set_model(1'b0, 32'h20, 32'h0, 4'h0, cyc + 1);
    repeat (3) @(negedge clk);
    #1 i_request = 1'b0;
    wait_done(lat2, rd2, 1'b0);
    chk("hold_rd1", rd, 32'hAA22CC44);
    chk("hold_rd2", rd2, 32'hAA22CC44);
    chk("hold_lat2", 32'(lat2), 32'd3);
    repeat (4) @(negedge clk);
    chk("hold_nreq", 32'(n_req - r0), 32'd2);

    // Reset in the middle of a read-merge-write, then a stray RAM ready.
    r0 = n_req;
    start_txn(1'b1, 32'h30, 32'hCAFEF00D, 4'b0011);
    repeat (2) @(negedge clk);
    #1;
    i_reset_n = 1'b0; i_request = 1'b0;
    m_kind = K_NONE; m_zero = 1'b1;
    #1;
    chk("rst_ctrl", {28'b0, o_ready, o_busy, o_mem_request, o_mem_rw}, 32'h0);
    chk("rst_addr", o_mem_address | o_mem_wdata | o_rdata, 32'h0);
    repeat (2) @(negedge clk);
    #1 i_reset_n = 1'b1;
    @(negedge clk);
    #1 stray = 1'b1;
    @(negedge clk);
    #1 stray = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_nreq", 32'(n_req - r0), 32'd1);
    run_txn(1'b0, 32'h20, 32'h0, 4'h0, lat, rd);
    chk("post_rst_rdata", rd, 32'hAA22CC44);
    chk("post_rst_lat", 32'(lat), 32'd3);

    // Randomized accesses over a small window of words so merges see earlier writes.
    for (int i = 0; i < 60; i++) begin
      rw = 1'($urandom());
      case ($urandom_range(0, 3))
        0:       mk = 4'h0;
        1:       mk = 4'hF;
        default: mk = 4'($urandom());
      endcase
      a = ($urandom_range(0, 31) << 2) | 32'($urandom_range(0, 3));
      d = $urandom();
      run_txn(rw, a, d, mk, lat, rd);
      chk("rand_lat", 32'(lat), 32'(exp_lat(rw, mk)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    diffs = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== model_mem[i]) diffs++;
    chk("ram_final_diffs", 32'(diffs), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
